// File: rtl/imem_port_arbiter_if.sv
// Instruction-memory port bundle shared by the arbiter, the fetch stage,
// the loader/debug port and the memory macro.
//   slave  : arbiter side (takes requests, drives grants/responses/memory)
//   master : requester + memory side (drives requests and mem_rdata)
// Carries the fetch request/response, loader request/response, ld_lock and the
// single synchronous memory port (mem_en/mem_we/mem_addr/mem_wdata/mem_rdata).
interface imem_port_arbiter_if #(
   parameter int DEPTH_WORDS = 1024
);
   localparam int AW = $clog2(DEPTH_WORDS);

   logic          fetch_req_valid;
   logic [31:0]   fetch_req_addr;
   logic          fetch_req_ready;
   logic          fetch_rsp_valid;
   logic [31:0]   fetch_rsp_data;

   logic          ld_req_valid;
   logic          ld_req_we;
   logic [31:0]   ld_req_addr;
   logic [31:0]   ld_req_wdata;
   logic          ld_req_ready;
   logic          ld_rsp_valid;
   logic [31:0]   ld_rsp_data;
   logic          ld_rsp_err;
   logic          ld_lock;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   modport slave (
      input  fetch_req_valid, fetch_req_addr,
      output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
      input  ld_req_valid, ld_req_we, ld_req_addr, ld_req_wdata, ld_lock,
      output ld_req_ready, ld_rsp_valid, ld_rsp_data, ld_rsp_err,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output fetch_req_valid, fetch_req_addr,
      input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
      output ld_req_valid, ld_req_we, ld_req_addr, ld_req_wdata, ld_lock,
      input  ld_req_ready, ld_rsp_valid, ld_rsp_data, ld_rsp_err,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single instruction-memory port between the fetch stage and the
// loader/debug port. Fetch wins by default; the loader is force-granted after
// LD_MAX_WAIT consecutive losses, and ld_lock hands it the port exclusively.
// Each grant yields exactly one response one cycle later; out-of-range or
// misaligned accesses never touch memory.
// Ports: clk, rst (synchronous, active high), bus (imem_port_arbiter_if.slave).
//
// Response tag owner:
//   state      | meaning
//   OWN_NONE   | no access granted last cycle, no response due
//   OWN_FETCH  | fetch granted last cycle, fetch response due now
//   OWN_LD     | loader granted last cycle, loader response/ack due now
module imem_port_arbiter #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LD_MAX_WAIT = 4
) (
   input logic                   clk,
   input logic                   rst,
   imem_port_arbiter_if.slave    bus
);
   localparam int          AW  = $clog2(DEPTH_WORDS);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LD} owner_t;

   typedef struct packed {
      owner_t owner;
      logic   oob;
      logic   was_write;
   } tag_t;

   tag_t       tag_q, tag_d;
   logic [3:0] wait_q, wait_d;
   logic       f_gnt, ld_gnt;
   logic       f_oob, ld_err;

   assign f_oob  = {2'b00, bus.fetch_req_addr[31:2]} >= 32'(DEPTH_WORDS);
   assign ld_err = ({2'b00, bus.ld_req_addr[31:2]} >= 32'(DEPTH_WORDS)) ||
                   (bus.ld_req_addr[1:0] != 2'b00);

   always_comb begin
      f_gnt  = 1'b0;
      ld_gnt = 1'b0;
      if (!rst) begin
         if (bus.ld_lock) begin
            ld_gnt = bus.ld_req_valid;
         end else if ((wait_q == 4'(LD_MAX_WAIT)) && bus.ld_req_valid) begin
            ld_gnt = 1'b1;
         end else if (bus.fetch_req_valid) begin
            f_gnt = 1'b1;
         end else begin
            ld_gnt = bus.ld_req_valid;
         end
      end
   end

   always_comb begin
      tag_d  = '{owner: OWN_NONE, oob: 1'b0, was_write: 1'b0};
      wait_d = wait_q;
      if (f_gnt) begin
         tag_d = '{owner: OWN_FETCH, oob: f_oob, was_write: 1'b0};
      end else if (ld_gnt) begin
         tag_d = '{owner: OWN_LD, oob: ld_err, was_write: bus.ld_req_we};
      end
      if (!bus.ld_req_valid || ld_gnt) begin
         wait_d = 4'd0;
      end else if (wait_q < 4'(LD_MAX_WAIT)) begin
         wait_d = wait_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q  <= '{owner: OWN_NONE, oob: 1'b0, was_write: 1'b0};
         wait_q <= 4'd0;
      end else begin
         tag_q  <= tag_d;
         wait_q <= wait_d;
      end
   end

   assign bus.fetch_req_ready = f_gnt;
   assign bus.ld_req_ready    = ld_gnt;

   // Erroneous grants still produce a response but leave mem_en low, which
   // also drops erroneous loader writes.
   assign bus.mem_en    = (f_gnt && !f_oob) || (ld_gnt && !ld_err);
   assign bus.mem_we    = ld_gnt && !ld_err && bus.ld_req_we;
   assign bus.mem_addr  = ld_gnt ? bus.ld_req_addr[AW+1:2] : bus.fetch_req_addr[AW+1:2];
   assign bus.mem_wdata = bus.ld_req_wdata;

   // rst gates the response valids directly so a response due in a reset
   // cycle is suppressed.
   assign bus.fetch_rsp_valid = !rst && (tag_q.owner == OWN_FETCH);
   assign bus.fetch_rsp_data  = tag_q.oob ? NOP : bus.mem_rdata;
   assign bus.ld_rsp_valid    = !rst && (tag_q.owner == OWN_LD);
   assign bus.ld_rsp_err      = bus.ld_rsp_valid && tag_q.oob;
   assign bus.ld_rsp_data     = (bus.ld_rsp_valid && !tag_q.oob && !tag_q.was_write)
                                ? bus.mem_rdata : 32'h0;
endmodule

// File: tb/tb_imem_port_arbiter.sv
module tb_imem_port_arbiter;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;

   imem_port_arbiter_if #(.DEPTH_WORDS(DEPTH)) bus ();

   imem_port_arbiter #(.DEPTH_WORDS(DEPTH), .LD_MAX_WAIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory model; preload happens on reset edges so only this block writes mem.
   always @(posedge clk) begin
      if (rst) begin
         mem[0] <= 32'h1111_1111;
         mem[5] <= 32'hDEAD_BEEF;
         mem[6] <= 32'h00A0_0093;
      end
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else            rdata_q <= mem[bus.mem_addr];
      end
   end
   assign bus.mem_rdata = rdata_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fetch(input logic v, input logic [31:0] a);
      bus.fetch_req_valid = v;
      bus.fetch_req_addr  = a;
   endtask

   task automatic ld(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
      bus.ld_req_valid = v;
      bus.ld_req_we    = we;
      bus.ld_req_addr  = a;
      bus.ld_req_wdata = d;
   endtask

   initial begin
      bus.ld_lock = 1'b0;
      fetch(1'b1, 32'h14);
      ld(1'b1, 1'b0, 32'h40, 32'h0);

      // Reset held 3 cycles with both requesters valid.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("rst_f_ready", 32'(bus.fetch_req_ready), 32'd0);
         chk("rst_ld_ready", 32'(bus.ld_req_ready), 32'd0);
         chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      end

      // First cycle after reset: fetch 0x14.
      @(negedge clk);
      rst = 1'b0;
      ld(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("post_rst_f_rsp_valid", 32'(bus.fetch_rsp_valid), 32'd0);
      chk("post_rst_ld_rsp_valid", 32'(bus.ld_rsp_valid), 32'd0);
      chk("post_rst_ld_rsp_err", 32'(bus.ld_rsp_err), 32'd0);
      chk("f14_ready", 32'(bus.fetch_req_ready), 32'd1);
      chk("f14_mem_en", 32'(bus.mem_en), 32'd1);
      chk("f14_mem_addr", 32'(bus.mem_addr), 32'd5);
      chk("f14_mem_we", 32'(bus.mem_we), 32'd0);

      // Back-to-back: fetch 0x18.
      @(negedge clk);
      chk("f14_rsp_valid", 32'(bus.fetch_rsp_valid), 32'd1);
      chk("f14_rsp_data", bus.fetch_rsp_data, 32'hDEAD_BEEF);
      fetch(1'b1, 32'h18);
      #1;
      chk("f18_ready", 32'(bus.fetch_req_ready), 32'd1);

      // Out-of-range fetch.
      @(negedge clk);
      chk("f18_rsp_valid", 32'(bus.fetch_rsp_valid), 32'd1);
      chk("f18_rsp_data", bus.fetch_rsp_data, 32'h00A0_0093);
      fetch(1'b1, 32'h1000);
      #1;
      chk("foob_ready", 32'(bus.fetch_req_ready), 32'd1);
      chk("foob_mem_en", 32'(bus.mem_en), 32'd0);

      // Out-of-range loader write.
      @(negedge clk);
      chk("foob_rsp_valid", 32'(bus.fetch_rsp_valid), 32'd1);
      chk("foob_rsp_nop", bus.fetch_rsp_data, 32'h0000_0013);
      fetch(1'b0, 32'h0);
      ld(1'b1, 1'b1, 32'h1000, 32'hCAFE_F00D);
      #1;
      chk("ldwoob_ready", 32'(bus.ld_req_ready), 32'd1);
      chk("ldwoob_mem_en", 32'(bus.mem_en), 32'd0);

      // Misaligned loader read.
      @(negedge clk);
      chk("ldwoob_rsp_valid", 32'(bus.ld_rsp_valid), 32'd1);
      chk("ldwoob_rsp_err", 32'(bus.ld_rsp_err), 32'd1);
      chk("ldwoob_rsp_data", bus.ld_rsp_data, 32'h0);
      chk("ldwoob_mem0_kept", mem[0], 32'h1111_1111);
      ld(1'b1, 1'b0, 32'h2, 32'h0);
      #1;
      chk("ldmis_ready", 32'(bus.ld_req_ready), 32'd1);
      chk("ldmis_mem_en", 32'(bus.mem_en), 32'd0);

      // Starvation guard: cycle 0 here.
      @(negedge clk);
      chk("ldmis_rsp_valid", 32'(bus.ld_rsp_valid), 32'd1);
      chk("ldmis_rsp_err", 32'(bus.ld_rsp_err), 32'd1);
      chk("ldmis_rsp_data", bus.ld_rsp_data, 32'h0);
      fetch(1'b1, 32'h14);
      ld(1'b1, 1'b0, 32'h18, 32'h0);
      for (int c = 0; c < 4; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         chk($sformatf("starve_c%0d_f_ready", c), 32'(bus.fetch_req_ready), 32'd1);
         chk($sformatf("starve_c%0d_ld_ready", c), 32'(bus.ld_req_ready), 32'd0);
      end
      @(negedge clk); #1;
      chk("starve_c4_ld_ready", 32'(bus.ld_req_ready), 32'd1);
      chk("starve_c4_f_ready", 32'(bus.fetch_req_ready), 32'd0);
      chk("starve_c4_mem_addr", 32'(bus.mem_addr), 32'd6);

      @(negedge clk);
      chk("starve_ld_rsp_valid", 32'(bus.ld_rsp_valid), 32'd1);
      chk("starve_ld_rsp_data", bus.ld_rsp_data, 32'h00A0_0093);
      chk("starve_ld_rsp_err", 32'(bus.ld_rsp_err), 32'd0);
      chk("starve_c4_no_f_rsp", 32'(bus.fetch_rsp_valid), 32'd0);
      ld(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("starve_c5_f_ready", 32'(bus.fetch_req_ready), 32'd1);

      // Lock mode: loader write 0x12345678 to 0x40 while fetch stays valid.
      @(negedge clk);
      chk("c5_f_rsp_data", bus.fetch_rsp_data, 32'hDEAD_BEEF);
      bus.ld_lock = 1'b1;
      ld(1'b1, 1'b1, 32'h40, 32'h1234_5678);
      #1;
      chk("lockw_f_ready", 32'(bus.fetch_req_ready), 32'd0);
      chk("lockw_ld_ready", 32'(bus.ld_req_ready), 32'd1);
      chk("lockw_mem_we", 32'(bus.mem_we), 32'd1);
      chk("lockw_mem_addr", 32'(bus.mem_addr), 32'd16);
      chk("lockw_mem_wdata", bus.mem_wdata, 32'h1234_5678);

      @(negedge clk);
      chk("lockw_ack_valid", 32'(bus.ld_rsp_valid), 32'd1);
      chk("lockw_ack_err", 32'(bus.ld_rsp_err), 32'd0);
      chk("lockw_ack_data", bus.ld_rsp_data, 32'h0);
      ld(1'b1, 1'b0, 32'h40, 32'h0);
      #1;
      chk("lockr_f_ready", 32'(bus.fetch_req_ready), 32'd0);
      chk("lockr_ld_ready", 32'(bus.ld_req_ready), 32'd1);

      // Release lock: fetch granted in the same cycle.
      @(negedge clk);
      chk("lockr_rsp_data", bus.ld_rsp_data, 32'h1234_5678);
      chk("lockr_rsp_err", 32'(bus.ld_rsp_err), 32'd0);
      bus.ld_lock = 1'b0;
      ld(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("unlock_f_ready", 32'(bus.fetch_req_ready), 32'd1);

      // Reset in the cycle the fetch response is due.
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rstdue_f_rsp_valid", 32'(bus.fetch_rsp_valid), 32'd0);
      chk("rstdue_f_ready", 32'(bus.fetch_req_ready), 32'd0);
      chk("rstdue_mem_en", 32'(bus.mem_en), 32'd0);

      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("after_rst_f_rsp_valid", 32'(bus.fetch_rsp_valid), 32'd0);
      chk("after_rst_f_ready", 32'(bus.fetch_req_ready), 32'd1);

      @(negedge clk);
      chk("after_rst_rsp_data", bus.fetch_rsp_data, 32'hDEAD_BEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Shares the single synchronous port of the instruction memory between two requesters: the pipeline fetch stage and the program loader/debug port. Each cycle it grants at most one request. Fetch has default priority, and a wait counter guarantees the loader is never starved. A lock input gives the loader exclusive access while the core is held. Every granted access gets exactly one response one cycle later, and out-of-range accesses are handled without touching memory.

## Interface
- DEPTH_WORDS, 1024: memory depth in 32-bit words; word index = addr[31:2].
- LD_MAX_WAIT, 4: consecutive cycles the loader may lose to fetch before it is force-granted once (1..15).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req_valid  in  1  fetch read request.
- fetch_req_addr  in  32  byte address; bits [1:0] ignored.
- fetch_req_ready  out  1  fetch request granted this cycle.
- fetch_rsp_valid  out  1  fetch response valid.
- fetch_rsp_data  out  32  instruction word.
- ld_req_valid  in  1  loader request.
- ld_req_we  in  1  1 = write, 0 = read.
- ld_req_addr  in  32  byte address.
- ld_req_wdata  in  32  write data.
- ld_req_ready  out  1  loader request granted this cycle.
- ld_rsp_valid  out  1  loader response valid (read data or write ack).
- ld_rsp_data  out  32  read data; 0 for write acks and errors.
- ld_rsp_err  out  1  the response's request was out of range or unaligned.
- ld_lock  in  1  1 = loader-exclusive mode; fetch is never granted.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  $clog2(DEPTH_WORDS)  word index.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data; valid the cycle after mem_en with mem_we=0.

## Operation
- **Grant rules**, evaluated combinationally each cycle. At most one grant per cycle.
  - If ld_lock=1: grant the loader when ld_req_valid=1; never grant fetch.
  - Else, if wait_cnt == LD_MAX_WAIT and ld_req_valid=1: grant the loader.
  - Else, if fetch_req_valid=1: grant fetch.
  - Else, if ld_req_valid=1: grant the loader.
- **wait_cnt** (4-bit register):
  - Increments when ld_req_valid=1 and the loader is not granted.
  - Clears when the loader is granted, or when ld_req_valid=0.
  - Saturates at LD_MAX_WAIT.
- **Range checks:**
  - A fetch is out of range (OOB) when addr[31:2] >= DEPTH_WORDS.
  - A loader request is in error when addr[31:2] >= DEPTH_WORDS or addr[1:0] != 0.
- **Memory access on a grant:**
  - An in-range grant drives mem_en=1, mem_addr=addr[31:2] truncated, mem_we=ld_req_we for the loader (0 for fetch), and mem_wdata=ld_req_wdata.
  - An OOB or error grant drives mem_en=0. A loader write in error is dropped.
- **Response tracking:** a registered response tag {owner: NONE/FETCH/LD, oob, was_write} is captured on every grant and cleared to NONE otherwise.
- **Response data:**
  - Fetch: mem_rdata if in range; 32'h00000013 (NOP) if OOB.
  - Loader in-range read: ld_rsp_data=mem_rdata.
  - Loader in-range write: ld_rsp_data=0, ld_rsp_err=0.
  - Loader in error: ld_rsp_data=0, ld_rsp_err=1.
- Responses cannot be back-pressured; requesters must accept them.
- Request fields must be stable while valid=1 and ready=0.

## Timing
- Grant and the mem_* outputs are combinational from the same-cycle request inputs.
- Request handshake completes in cycle N when valid=1 and ready=1.
- The response is valid in cycle N+1 for exactly one cycle. Latency = 1.
- Throughput: one access per cycle, back to back.
- While rst=1:
  - fetch_req_ready, ld_req_ready and mem_en are forced to 0.
  - On the edge: response tag is set to NONE and wait_cnt to 0.
  - Cycle after rst deasserts: fetch_rsp_valid=0, ld_rsp_valid=0, ld_rsp_err=0.
- Reset asserted in the cycle a response is due: the response is suppressed (valid=0) and no access is issued that cycle.
- Reset values (registered-driven outputs): *_rsp_valid=0, ld_rsp_err=0, ld_rsp_data=0. fetch_rsp_data is unspecified when fetch_rsp_valid=0.
- ld_lock may change on any cycle. It affects the grant in the same cycle and never cancels a response already in flight.
- Fetch and loader both valid with wait_cnt < LD_MAX_WAIT: fetch wins and wait_cnt increments.

## Test plan
- **Reset:** hold rst=1 for 3 cycles with both requesters valid -> no ready, mem_en=0; after release, first response appears 1 cycle after the first grant.
- **Back-to-back fetches:** preload word 5 = 0xDEADBEEF, word 6 = 0x00A00093; fetch addr 0x14 then 0x18 on consecutive cycles -> fetch_rsp_data 0xDEADBEEF, then 0x00A00093, one cycle after each grant.
- **Out of range:**
  - Fetch addr 0x1000 (DEPTH_WORDS=1024) -> mem_en=0; next cycle fetch_rsp_data=0x00000013.
  - Loader write to 0x1000 -> ld_rsp_err=1, memory unchanged.
  - Loader read at 0x2 -> ld_rsp_err=1, ld_rsp_data=0.
- **Starvation guard:** fetch valid continuously, loader read valid from cycle 0, LD_MAX_WAIT=4 -> fetch granted cycles 0-3, loader granted cycle 4, fetch granted cycle 5.
- **Lock mode:** ld_lock=1; loader writes 0x12345678 to 0x40, then reads 0x40 -> fetch_req_ready stays 0, write ack has err=0, read returns 0x12345678; releasing ld_lock lets fetch be granted the same cycle.
